// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Raster constants for the 640x480@60 (800x525 total) VGA stream, the receive
// FSM state type, and the CRC-16-CCITT step used by the optional frame CRC.
// No ports.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  typedef enum logic [1:0] {HUNT, HLOCK, LOCKED} rx_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One 12-bit pixel folded into the CRC, MSB first.
  function automatic logic [15:0] crc16_12(input logic [15:0] crc_in,
                                           input logic [11:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// vga_rx_crc16
// CRC-16-CCITT accumulator, one 12-bit pixel per enabled clk.
// Ports: clk, reset (async, active low), en (fold data in), clr (re-init,
// wins over en), data[11:0], crc[15:0] (running state).
module vga_rx_crc16
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [11:0] data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en)  crc <= crc16_12(crc, data);
  end

endmodule

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder
// Locks onto an incoming VGA hsync/vsync/rgb stream sampled on each pixel tick,
// regenerates pixel coordinates, flags active video and reports sync errors.
// Ports:
//   clk, reset (async, active low), tick (pixel strobe)
//   hsync, vsync (active low), rgb[11:0]             - incoming stream
//   rx_x, rx_y, rx_rgb, rx_valid                     - recovered pixel
//   locked, frame_done, sync_err, err_count[7:0]     - status
//   frame_crc[15:0]                                  - previous frame CRC
// Build option: define VGA_RX_CRC_EN to include the frame CRC; otherwise
// frame_crc is tied to zero.
//
// state  | meaning
// HUNT   | waiting for an hsync fall; counters held
// HLOCK  | x aligned to hsync, waiting for vsync fall at x==0
// LOCKED | raster aligned; every sample checked against expected sync
module vga_rx_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [11:0] rx_rgb,
  output logic        rx_valid,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] HT_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VT_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] HA       = 10'(H_ACTIVE);
  localparam logic [9:0] VA       = 10'(V_ACTIVE);

  rx_state_t  state;
  logic [9:0] x, y;
  logic [9:0] cx, cy;
  logic       prev_h, prev_v;
  logic       fall_h, fall_v;
  logic       exp_h, exp_v;
  logic       mismatch, in_active, at_last;

  // x/y hold the coordinate of the last sample; cx/cy are the coordinate the
  // current sample gets if the raster free-runs.
  assign cx = (x == HT_LAST) ? 10'd0 : x + 10'd1;
  assign cy = (x != HT_LAST) ? y : ((y == VT_LAST) ? 10'd0 : y + 10'd1);

  assign fall_h    = prev_h & ~hsync;
  assign fall_v    = prev_v & ~vsync;
  assign exp_h     = ~((cx >= HS_FIRST) && (cx <= HS_LAST));
  assign exp_v     = ~((cy >= VS_FIRST) && (cy <= VS_LAST));
  assign mismatch  = (hsync != exp_h) || (vsync != exp_v);
  assign in_active = (cx < HA) && (cy < VA);
  assign at_last   = (cx == HA - 10'd1) && (cy == VA - 10'd1);

  assign rx_x = x;
  assign rx_y = y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      x          <= '0;
      y          <= '0;
      prev_h     <= 1'b1;
      prev_v     <= 1'b1;
      rx_rgb     <= '0;
      rx_valid   <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
      if (tick) begin
        prev_h <= hsync;
        prev_v <= vsync;
        rx_rgb <= rgb;
        case (state)
          HUNT: begin
            rx_valid <= 1'b0;
            locked   <= 1'b0;
            if (fall_h) begin
              x     <= HS_FIRST;
              state <= HLOCK;
            end
          end
          HLOCK: begin
            x        <= cx;
            y        <= cy;
            rx_valid <= 1'b0;
            if (fall_h && (cx != HS_FIRST)) begin
              state <= HUNT;
            end else if (fall_v && (cx == 10'd0)) begin
              y      <= VS_FIRST;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            x <= cx;
            y <= cy;
            if (mismatch) begin
              sync_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state    <= HUNT;
              locked   <= 1'b0;
              rx_valid <= 1'b0;
            end else begin
              rx_valid <= in_active;
              if (at_last) frame_done <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;
  logic        crc_en, crc_clr, crc_take;

  assign crc_en   = tick && (state == LOCKED) && !mismatch && in_active;
  assign crc_take = tick && (state == LOCKED) && !mismatch && at_last;
  assign crc_clr  = tick && (state == LOCKED) && (mismatch || at_last);

  vga_rx_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .en    (crc_en),
    .clr   (crc_clr),
    .data  (rgb),
    .crc   (crc)
  );

  // The last pixel is folded in here directly since the engine re-inits on
  // the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        frame_crc <= '0;
    else if (crc_take) frame_crc <= crc16_12(crc, rgb);
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
module tb_vga_rx_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s_tick, s_h, s_v;
  logic [11:0] s_rgb;
  logic [9:0]  s_x, s_y;
  logic [11:0] s_orgb;
  logic        s_valid, s_locked, s_fd, s_err;
  logic [7:0]  s_cnt;
  logic [15:0] s_crc;

  logic        f_tick, f_h, f_v;
  logic [11:0] f_rgb;
  logic [9:0]  f_x, f_y;
  logic [11:0] f_orgb;
  logic        f_valid, f_locked, f_fd, f_err;
  logic [7:0]  f_cnt;
  logic [15:0] f_crc;

  // Reduced raster: 10x8 total, active 6x4, hsync x=7..8, vsync y=5..6.
  vga_rx_decoder #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .reset(rst_n), .tick(s_tick), .hsync(s_h), .vsync(s_v), .rgb(s_rgb),
    .rx_x(s_x), .rx_y(s_y), .rx_rgb(s_orgb), .rx_valid(s_valid), .locked(s_locked),
    .frame_done(s_fd), .sync_err(s_err), .err_count(s_cnt), .frame_crc(s_crc)
  );

  vga_rx_decoder u_full (
    .clk(clk), .reset(rst_n), .tick(f_tick), .hsync(f_h), .vsync(f_v), .rgb(f_rgb),
    .rx_x(f_x), .rx_y(f_y), .rx_rgb(f_orgb), .rx_valid(f_valid), .locked(f_locked),
    .frame_done(f_fd), .sync_err(f_err), .err_count(f_cnt), .frame_crc(f_crc)
  );

  bit use_full = 1'b1;
  logic [9:0]  o_x, o_y;
  logic [11:0] o_rgb;
  logic        o_valid, o_locked, o_fd, o_err;
  logic [7:0]  o_cnt;
  logic [15:0] o_crc;
  assign o_x      = use_full ? f_x      : s_x;
  assign o_y      = use_full ? f_y      : s_y;
  assign o_rgb    = use_full ? f_orgb   : s_orgb;
  assign o_valid  = use_full ? f_valid  : s_valid;
  assign o_locked = use_full ? f_locked : s_locked;
  assign o_fd     = use_full ? f_fd     : s_fd;
  assign o_err    = use_full ? f_err    : s_err;
  assign o_cnt    = use_full ? f_cnt    : s_cnt;
  assign o_crc    = use_full ? f_crc    : s_crc;

  int n_cmp = 0, n_bad = 0;

  // Raster under test
  int ha, va, ht, vt, hs, he, vs, ve;
  // Source truth: coordinate of the next sample to send
  int sx, sy, rgbm, gap_max;
  // Reference model
  int m_mode, m_off, m_err, valid_cnt;
  bit m_ph, m_pv;
  logic [15:0] m_crc, m_fcrc;

  typedef struct {
    int kind;     // 0 clean, 1 hsync forced low, 2 vsync forced low, 3 reset
    int px, py;
    int rgbm;
    int exp_err;
    bit exp_lock;
  } step_t;
  step_t steps [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (src x=%0d y=%0d)", name, act, exp, sx, sy);
    end
  endtask

  function automatic bit ih(int x);
    return !(x >= hs && x <= he);
  endfunction
  function automatic bit iv(int y);
    return !(y >= vs && y <= ve);
  endfunction
  function automatic logic [11:0] pong(int x, int y);
    return ((x >= 1 && x <= 2 && y >= 1 && y <= 2) || x == 4) ? 12'hFFF : 12'h000;
  endfunction
  function automatic logic [15:0] crc_px(logic [15:0] c, logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) r = (r << 1) ^ (((r[15] ^ d[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  task automatic set_timing(int a, int fp, int sw, int bp, int b, int vfp, int vsw, int vbp);
    ha = a; hs = a + fp; he = a + fp + sw - 1; ht = a + fp + sw + bp;
    va = b; vs = b + vfp; ve = b + vfp + vsw - 1; vt = b + vfp + vsw + vbp;
  endtask

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_err = 0; m_ph = 1; m_pv = 1;
    m_crc = 16'hFFFF; m_fcrc = 16'h0000; valid_cnt = 0;
  endtask

  // Send one sample at the source's current coordinate and check the result.
  task automatic pix(input int kind);
    bit h, v, fh, fv, e_err, e_fd, e_lock, e_valid, was_hunt;
    logic [11:0] p;
    int dx;
    h = ih(sx); v = iv(sy);
    if (kind == 1) h = 1'b0;
    if (kind == 2) v = 1'b0;
    if (rgbm == 0) p = 12'($urandom);
    else           p = pong(sx, sy);
    if (rgbm == 2 && sx == 1 && sy == 1) p = 12'h00F;
    if (use_full) begin f_h = h; f_v = v; f_rgb = p; f_tick = 1'b1; end
    else          begin s_h = h; s_v = v; s_rgb = p; s_tick = 1'b1; end
    @(posedge clk); #1;
    f_tick = 1'b0; s_tick = 1'b0;

    fh = m_ph && !h; fv = m_pv && !v; m_ph = h; m_pv = v;
    e_err = 0; e_fd = 0; was_hunt = (m_mode == 0);
    dx = (sx + m_off) % ht;
    if (m_mode == 0) begin
      if (fh) begin m_mode = 1; m_off = (hs - sx + ht) % ht; end
    end else if (m_mode == 1) begin
      if (fh && dx != hs) m_mode = 0;
      else if (fv && dx == 0) m_mode = 2;
    end else begin
      if (h != ih(sx) || v != iv(sy)) begin
        e_err = 1; m_mode = 0; m_crc = 16'hFFFF;
        if (m_err < 255) m_err++;
      end else if (sx == ha - 1 && sy == va - 1) e_fd = 1;
    end
    e_lock  = (m_mode == 2);
    e_valid = e_lock && sx < ha && sy < va;
    if (e_valid) m_crc = crc_px(m_crc, p);
    if (e_fd) begin m_fcrc = m_crc; m_crc = 16'hFFFF; end

    chk("locked", o_locked, e_lock);
    chk("rx_valid", o_valid, e_valid);
    chk("sync_err", o_err, e_err);
    chk("frame_done", o_fd, e_fd);
    chk("err_count", o_cnt, m_err);
    chk("rx_rgb", o_rgb, p);
    if (e_lock) begin
      chk("rx_x", o_x, sx);
      chk("rx_y", o_y, sy);
    end
    if (was_hunt && m_mode == 1) chk("hunt_load_x", o_x, hs);
`ifdef VGA_RX_CRC_EN
    chk("frame_crc", o_crc, m_fcrc);
`else
    chk("frame_crc_tied", o_crc, 0);
`endif
    if (!o_locked) valid_cnt = 0;
    else if (o_valid) valid_cnt++;
    if (o_fd) begin
      chk("valid_per_frame", valid_cnt, ha * va);
      valid_cnt = 0;
    end

    sx++;
    if (sx == ht) begin sx = 0; sy = (sy + 1) % vt; end

    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
      chk("pulse_err_clear", o_err, 0);
      chk("pulse_fd_clear", o_fd, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"}, o_x, 0);
    chk({tag, "_y"}, o_y, 0);
    chk({tag, "_rgb"}, o_rgb, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_fd"}, o_fd, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_cnt"}, o_cnt, 0);
    chk({tag, "_crc"}, o_crc, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_to(input int px, input int py, input int kind);
    int n;
    n = 0;
    while (!(sx == px && sy == py)) begin
      pix(0);
      n++;
      if (n > ht * vt + 2) begin
        n_cmp++; n_bad++;
        $display("FAIL run_to_timeout: got %0d samples required <= %0d", n, ht * vt + 2);
        return;
      end
    end
    if (kind == 3) do_reset();
    else           pix(kind);
  endtask

  task automatic run_n(input int n);
    repeat (n) pix(0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c1, c2, c3, gold;
    steps[0] = '{0, 0, 0, 0, 0, 1'b1};
    steps[1] = '{1, 6, 1, 0, 1, 1'b1};
    steps[2] = '{2, 2, 1, 0, 2, 1'b1};
    steps[3] = '{0, 0, 0, 1, 2, 1'b1};
    steps[4] = '{3, 3, 2, 0, 0, 1'b1};
    steps[5] = '{1, 6, 6, 0, 1, 1'b1};
    steps[6] = '{2, 0, 7, 0, 2, 1'b1};
    steps[7] = '{0, 0, 0, 2, 2, 1'b1};

    rst_n = 1'b0;
    s_tick = 0; s_h = 1; s_v = 1; s_rgb = 0;
    f_tick = 0; f_h = 1; f_v = 1; f_rgb = 0;
    rgbm = 0; gap_max = 0;
    repeat (3) @(posedge clk);
    #1;
    use_full = 1; #1 check_zero("reset_full");
    use_full = 0; #1 check_zero("reset_small");
    rst_n = 1'b1;

    // Full 800x525 raster, source starting mid-frame.
    use_full = 1;
    set_timing(640, 16, 96, 48, 480, 10, 2, 33);
    model_reset();
    sx = 600; sy = 489;
    run_to(0, 490, 0);
    chk("full_lock_at_0_490", o_locked, 1);
    run_to(655, 491, 1);
    chk("full_early_h_err", o_cnt, 1);
    chk("full_early_h_unlock", o_locked, 0);
    run_n(200);

    // Reduced raster, random start point and random tick spacing.
    use_full = 0;
    set_timing(6, 1, 2, 1, 4, 1, 2, 1);
    model_reset();
    sx = $urandom_range(0, 9); sy = $urandom_range(0, 7);
    gap_max = 2;
    for (int i = 0; i < 8; i++) begin
      run_to(steps[i].px, steps[i].py, steps[i].kind);
      rgbm = steps[i].rgbm;
      run_n(2 * ht * vt);
      chk($sformatf("step%0d_err_count", i), o_cnt, steps[i].exp_err);
      chk($sformatf("step%0d_locked", i), o_locked, steps[i].exp_lock);
    end

    // Frame CRC: two identical Pong frames, then one with a flipped pixel.
    gold = 16'hFFFF;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 6; x++) gold = crc_px(gold, pong(x, y));
    run_to(9, 7, 0);
    rgbm = 1;
    run_to(5, 3, 0); c1 = o_crc;
    run_to(5, 3, 0); c2 = o_crc;
    rgbm = 2;
    run_to(5, 3, 0); c3 = o_crc;
    rgbm = 0;
`ifdef VGA_RX_CRC_EN
    chk("crc_golden", c1, gold);
    chk("crc_repeat", c2, c1);
    chk("crc_flip_differs", c3 != c1, 1);
`else
    chk("crc_tied_zero", c1 | c2 | c3, 0);
`endif

    // Error counter saturation: one early hsync per relocked frame.
    gap_max = 0;
    for (int i = 0; i < 258; i++) run_to(6, 5, 1);
    chk("err_count_saturated", o_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
